// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 porch/sync defaults and geometry helpers shared by the raster
// timing generator and its per-axis counters.
package vga_timing_pkg;

  localparam int unsigned VGA_CLK_DIV  = 2;
  localparam int unsigned VGA_H_ACTIVE = 640;
  localparam int unsigned VGA_H_FP     = 16;
  localparam int unsigned VGA_H_SYNC   = 96;
  localparam int unsigned VGA_H_BP     = 48;
  localparam int unsigned VGA_V_ACTIVE = 480;
  localparam int unsigned VGA_V_FP     = 10;
  localparam int unsigned VGA_V_SYNC   = 2;
  localparam int unsigned VGA_V_BP     = 33;
  localparam int unsigned VGA_POS_W    = 11;

  function automatic int unsigned axis_total(input int unsigned active, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return active + fp + sync + bp;
  endfunction

  // A counter of width w can hold every position 0..total-1.
  function automatic bit pos_w_fits(input int unsigned w, input int unsigned total);
    return w >= $clog2(total);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one raster axis (horizontal or vertical). Counts and wraps on i_Step,
// registers position and sync, and exposes the next-state active decode and wrap flag.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned FP     = VGA_H_FP,
  parameter int unsigned SYNC   = VGA_H_SYNC,
  parameter int unsigned BP     = VGA_H_BP,
  parameter bit          POL    = 1'b0,
  parameter int unsigned POS_W  = VGA_POS_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Clr,
  input  logic             i_Step,
  output logic [POS_W-1:0] o_Pos,
  output logic             o_Sync,
  output logic             o_NxtActive,
  output logic             o_Wrap
);

  localparam int unsigned      TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [POS_W-1:0] LAST     = POS_W'(TOTAL - 1);
  localparam logic [POS_W-1:0] ACT_END  = POS_W'(ACTIVE);
  localparam logic [POS_W-1:0] SYNC_BEG = POS_W'(ACTIVE + FP);
  localparam logic [POS_W-1:0] SYNC_END = POS_W'(ACTIVE + FP + SYNC);

  logic [POS_W-1:0] pos_nxt;
  logic             sync_nxt;

  // Decodes come from pos_nxt so the registered sync lands with the position it describes.
  always_comb begin
    pos_nxt = o_Pos;
    o_Wrap  = 1'b0;
    if (i_Clr) begin
      pos_nxt = '0;
    end else if (i_Step) begin
      o_Wrap  = (o_Pos == LAST);
      pos_nxt = o_Wrap ? '0 : o_Pos + 1'b1;
    end
    sync_nxt    = !i_Clr && (pos_nxt >= SYNC_BEG) && (pos_nxt < SYNC_END);
    o_NxtActive = !i_Clr && (pos_nxt < ACT_END);
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_Pos  <= '0;
      o_Sync <= ~POL;
    end else begin
      o_Pos  <= pos_nxt;
      o_Sync <= sync_nxt ? POL : ~POL;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing (divider, H/V counters, syncs, strobes).
// Define VGA_TEST_PATTERN_EN to add registered colour-bar outputs o_Red/o_Green/o_Blue.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CLK_DIV  = VGA_CLK_DIV,
  parameter int unsigned H_ACTIVE = VGA_H_ACTIVE,
  parameter int unsigned H_FP     = VGA_H_FP,
  parameter int unsigned H_SYNC   = VGA_H_SYNC,
  parameter int unsigned H_BP     = VGA_H_BP,
  parameter int unsigned V_ACTIVE = VGA_V_ACTIVE,
  parameter int unsigned V_FP     = VGA_V_FP,
  parameter int unsigned V_SYNC   = VGA_V_SYNC,
  parameter int unsigned V_BP     = VGA_V_BP,
  parameter bit          HS_POL   = 1'b0,
  parameter bit          VS_POL   = 1'b0,
  parameter int unsigned POS_W    = VGA_POS_W
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_Enable,
  output logic             o_PixTick,
  output logic [POS_W-1:0] o_HPos,
  output logic [POS_W-1:0] o_VPos,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic             o_LineStart,
  output logic             o_FrameStart
`ifdef VGA_TEST_PATTERN_EN
  ,
  output logic [3:0]       o_Red,
  output logic [3:0]       o_Green,
  output logic [3:0]       o_Blue
`endif
);

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (!pos_w_fits(POS_W, (H_TOTAL > V_TOTAL) ? H_TOTAL : V_TOTAL) ||
      (CLK_DIV < 1) || (CLK_DIV > 16)) begin : g_bad_cfg
    $error("vga_timing_gen: POS_W too narrow or CLK_DIV outside 1..16");
  end

  logic [DIV_W-1:0] div_q;
  logic clr, tick, h_wrap, v_wrap, h_nact, v_nact;

  assign clr  = !i_Enable;
  assign tick = i_Enable && (div_q == DIV_LAST);

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n)          div_q <= '0;
    else if (clr || tick)  div_q <= '0;
    else                   div_q <= div_q + 1'b1;
  end

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(HS_POL), .POS_W(POS_W)
  ) u_h_axis (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Clr(clr), .i_Step(tick),
    .o_Pos(o_HPos), .o_Sync(o_HSync), .o_NxtActive(h_nact), .o_Wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(VS_POL), .POS_W(POS_W)
  ) u_v_axis (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_Clr(clr), .i_Step(h_wrap),
    .o_Pos(o_VPos), .o_Sync(o_VSync), .o_NxtActive(v_nact), .o_Wrap(v_wrap)
  );

  // o_Active only moves on a tick so the origin held during reset/disable reads inactive.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_PixTick    <= 1'b0;
      o_LineStart  <= 1'b0;
      o_FrameStart <= 1'b0;
      o_Active     <= 1'b0;
    end else begin
      o_PixTick    <= tick;
      o_LineStart  <= h_wrap;
      o_FrameStart <= v_wrap;
      if (clr)       o_Active <= 1'b0;
      else if (tick) o_Active <= h_nact && v_nact;
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int unsigned BAR_PX = H_ACTIVE / 8;

  logic [POS_W-1:0] h_next;
  logic [2:0]       bar;

  assign h_next = h_wrap ? '0 : o_HPos + 1'b1;
  assign bar    = 3'(h_next / POS_W'(BAR_PX));

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n || clr) begin
      o_Red   <= '0;
      o_Green <= '0;
      o_Blue  <= '0;
    end else if (tick) begin
      o_Red   <= (h_nact && v_nact && bar[0]) ? '1 : '0;
      o_Green <= (h_nact && v_nact && bar[1]) ? '1 : '0;
      o_Blue  <= (h_nact && v_nact && bar[2]) ? '1 : '0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: three generators (reduced geometry, reduced geometry at CLK_DIV=1 with
// active-high syncs, full 640x480 defaults) checked cycle by cycle against a reference model.
module tb_vga_timing_gen;

  typedef struct {
    int unsigned cdiv, ha, hfp, hsw, hbp, va, vfp, vsw, vbp;
    bit hpol, vpol;
  } geom_t;

  typedef struct {
    int unsigned div, h, v;
    bit tick, hs, vs, act, ls, fs, run;
    logic [3:0] r, g, b;
  } mst_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  always #5 clk = ~clk;

  logic a_tick, a_hs, a_vs, a_act, a_ls, a_fs;
  logic b_tick, b_hs, b_vs, b_act, b_ls, b_fs;
  logic c_tick, c_hs, c_vs, c_act, c_ls, c_fs;
  logic [5:0]  a_h, a_v, b_h, b_v;
  logic [10:0] c_h, c_v;
`ifdef VGA_TEST_PATTERN_EN
  logic [3:0] a_r, a_g, a_b, b_r, b_g, b_b, c_r, c_g, c_b;
`endif

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .HS_POL(1'b0), .VS_POL(1'b0), .POS_W(6)
  ) u_dut_a (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .o_PixTick(a_tick), .o_HPos(a_h),
    .o_VPos(a_v), .o_HSync(a_hs), .o_VSync(a_vs), .o_Active(a_act), .o_LineStart(a_ls),
    .o_FrameStart(a_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .o_Red(a_r), .o_Green(a_g), .o_Blue(a_b)
`endif
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(2), .V_BP(3), .HS_POL(1'b1), .VS_POL(1'b1), .POS_W(6)
  ) u_dut_b (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .o_PixTick(b_tick), .o_HPos(b_h),
    .o_VPos(b_v), .o_HSync(b_hs), .o_VSync(b_vs), .o_Active(b_act), .o_LineStart(b_ls),
    .o_FrameStart(b_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .o_Red(b_r), .o_Green(b_g), .o_Blue(b_b)
`endif
  );

  vga_timing_gen u_dut_c (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_Enable(en), .o_PixTick(c_tick), .o_HPos(c_h),
    .o_VPos(c_v), .o_HSync(c_hs), .o_VSync(c_vs), .o_Active(c_act), .o_LineStart(c_ls),
    .o_FrameStart(c_fs)
`ifdef VGA_TEST_PATTERN_EN
    , .o_Red(c_r), .o_Green(c_g), .o_Blue(c_b)
`endif
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic geom_t mk_geom(input int unsigned cdiv, ha, hfp, hsw, hbp,
                                    va, vfp, vsw, vbp, input bit hpol, vpol);
    geom_t g;
    g.cdiv = cdiv; g.ha = ha; g.hfp = hfp; g.hsw = hsw; g.hbp = hbp;
    g.va = va; g.vfp = vfp; g.vsw = vsw; g.vbp = vbp; g.hpol = hpol; g.vpol = vpol;
    return g;
  endfunction

  function automatic mst_t m_reset(input geom_t g);
    mst_t s;
    s.div = 0; s.h = 0; s.v = 0;
    s.tick = 0; s.ls = 0; s.fs = 0; s.act = 0; s.run = 0;
    s.hs = !g.hpol; s.vs = !g.vpol;
    s.r = 4'h0; s.g = 4'h0; s.b = 4'h0;
    return s;
  endfunction

  function automatic mst_t m_next(input mst_t s, input geom_t g, input bit go);
    mst_t n;
    int unsigned ht, vt, hsb, vsb, bar;
    if (!go) return m_reset(g);
    ht = g.ha + g.hfp + g.hsw + g.hbp;
    vt = g.va + g.vfp + g.vsw + g.vbp;
    n = s;
    n.tick = (s.div == g.cdiv - 1);
    n.ls = 0; n.fs = 0;
    n.div = n.tick ? 0 : s.div + 1;
    if (n.tick) begin
      n.run = 1'b1;
      n.h = (s.h + 1) % ht;
      if (n.h == 0) begin
        n.v  = (s.v + 1) % vt;
        n.ls = 1'b1;
        n.fs = (n.v == 0);
      end
    end
    hsb = g.ha + g.hfp;
    vsb = g.va + g.vfp;
    n.hs  = (n.h >= hsb && n.h < hsb + g.hsw) ? g.hpol : !g.hpol;
    n.vs  = (n.v >= vsb && n.v < vsb + g.vsw) ? g.vpol : !g.vpol;
    n.act = n.run && (n.h < g.ha) && (n.v < g.va);
    bar = n.h / (g.ha / 8);
    n.r = (n.act && bar[0]) ? 4'hF : 4'h0;
    n.g = (n.act && bar[1]) ? 4'hF : 4'h0;
    n.b = (n.act && bar[2]) ? 4'hF : 4'h0;
    return n;
  endfunction

  function automatic logic [63:0] pk(input bit t, l, f, a, hs, vs, input int unsigned h, v);
    logic [63:0] r;
    r = '0;
    r[37:32] = {t, l, f, a, hs, vs};
    r[31:16] = h[15:0];
    r[15:0]  = v[15:0];
    return r;
  endfunction

  function automatic logic [63:0] pks(input mst_t s);
    return pk(s.tick, s.ls, s.fs, s.act, s.hs, s.vs, s.h, s.v);
  endfunction

  geom_t ga, gb, gc;
  mst_t  sa, sb, sc;
  logic [63:0] q_a[$], q_b[$], q_c[$];

  // Expected outputs are queued at the clock edge where inputs are applied, compared half a cycle later.
  task automatic cycle();
    @(posedge clk);
    sa = m_next(sa, ga, en && rst_n);
    sb = m_next(sb, gb, en && rst_n);
    sc = m_next(sc, gc, en && rst_n);
    q_a.push_back(pks(sa));
    q_b.push_back(pks(sb));
    q_c.push_back(pks(sc));
    @(negedge clk);
    chk("a_out", pk(a_tick, a_ls, a_fs, a_act, a_hs, a_vs, a_h, a_v), q_a.pop_front());
    chk("b_out", pk(b_tick, b_ls, b_fs, b_act, b_hs, b_vs, b_h, b_v), q_b.pop_front());
    chk("c_out", pk(c_tick, c_ls, c_fs, c_act, c_hs, c_vs, c_h, c_v), q_c.pop_front());
`ifdef VGA_TEST_PATTERN_EN
    chk("a_rgb", {a_r, a_g, a_b}, {sa.r, sa.g, sa.b});
`endif
  endtask

  task automatic first_tick(input string tag);
    int n = 0;
    do begin
      cycle();
      n++;
    end while (!a_tick && n < 8);
    chk({tag, "_lat"}, n, 2);
    chk({tag, "_pos"}, {a_h, a_v}, {6'd1, 6'd0});
  endtask

  // Period and width measurements taken straight from the output strobes.
  int cyc = 0;
  int a_ls_t = -1, a_fs_t = -1, b_ls_t = -1, b_fs_t = -1, c_ls_t = -1;
  int a_hsl = 0, a_vsl = 0, b_hsh = 0, b_vsh = 0, c_hsl = 0;
  logic [11:0] a_prev = '0;

  always @(negedge clk) begin
    cyc++;
    if (!(rst_n && en)) begin
      a_ls_t = -1; a_fs_t = -1; b_ls_t = -1; b_fs_t = -1; c_ls_t = -1;
      a_hsl = 0; a_vsl = 0; b_hsh = 0; b_vsh = 0; c_hsl = 0;
    end else begin
      if (a_ls) begin
        if (a_ls_t >= 0) begin
          chk("a_line", cyc - a_ls_t, 64);
          chk("a_hs_low", a_hsl, 12);
        end
        a_ls_t = cyc; a_hsl = 0;
      end
      if (!a_hs) a_hsl++;
      if (a_fs) begin
        if (a_fs_t >= 0) begin
          chk("a_frame", cyc - a_fs_t, 1216);
          chk("a_vs_low", a_vsl, 128);
        end
        chk("a_fs_pos", {a_h, a_v}, 12'h000);
        chk("a_fs_prev", a_prev, {6'd31, 6'd18});
        a_fs_t = cyc; a_vsl = 0;
      end
      if (!a_vs) a_vsl++;
      if (a_tick && a_v == 6'd11 && a_h == 6'd15) chk("a_act_last", a_act, 1);
      if (a_tick && a_v == 6'd11 && a_h == 6'd16) chk("a_act_fall", a_act, 0);
      if (a_tick) a_prev = {a_h, a_v};

      if (b_ls) begin
        if (b_ls_t >= 0) begin
          chk("b_line", cyc - b_ls_t, 32);
          chk("b_hs_high", b_hsh, 6);
        end
        b_ls_t = cyc; b_hsh = 0;
      end
      if (b_hs) b_hsh++;
      if (b_fs) begin
        if (b_fs_t >= 0) begin
          chk("b_frame", cyc - b_fs_t, 608);
          chk("b_vs_high", b_vsh, 64);
        end
        b_fs_t = cyc; b_vsh = 0;
      end
      if (b_vs) b_vsh++;

      if (c_ls) begin
        if (c_ls_t >= 0) begin
          chk("c_line", cyc - c_ls_t, 1600);
          chk("c_hs_low", c_hsl, 192);
        end
        c_ls_t = cyc; c_hsl = 0;
      end
      if (!c_hs) c_hsl++;
      if (c_tick && c_h == 11'd655) chk("c_hs_655", c_hs, 1);
      if (c_tick && c_h == 11'd656) chk("c_hs_656", c_hs, 0);
      if (c_tick && c_h == 11'd752) chk("c_hs_752", c_hs, 1);
      if (c_tick && c_h == 11'd639) chk("c_act_639", c_act, 1);
      if (c_tick && c_h == 11'd640) chk("c_act_640", c_act, 0);
`ifdef VGA_TEST_PATTERN_EN
      if (c_tick && c_v == 11'd1 && c_h == 11'd0)   chk("c_rgb_0",   {c_r, c_g, c_b}, 12'h000);
      if (c_tick && c_v == 11'd1 && c_h == 11'd80)  chk("c_rgb_80",  {c_r, c_g, c_b}, 12'hF00);
      if (c_tick && c_v == 11'd1 && c_h == 11'd560) chk("c_rgb_560", {c_r, c_g, c_b}, 12'hFFF);
      if (c_tick && c_v == 11'd1 && c_h == 11'd700) chk("c_rgb_700", {c_r, c_g, c_b}, 12'h000);
`endif
    end
  end

  initial begin
    int n;
    ga = mk_geom(2, 16, 4, 6, 6, 12, 2, 2, 3, 1'b0, 1'b0);
    gb = mk_geom(1, 16, 4, 6, 6, 12, 2, 2, 3, 1'b1, 1'b1);
    gc = mk_geom(2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
    sa = m_reset(ga);
    sb = m_reset(gb);
    sc = m_reset(gc);
    en = 1'b1;

    repeat (3) cycle();
    chk("rst_a", pk(a_tick, a_ls, a_fs, a_act, a_hs, a_vs, a_h, a_v), pk(0, 0, 0, 0, 1, 1, 0, 0));
    chk("rst_b", pk(b_tick, b_ls, b_fs, b_act, b_hs, b_vs, b_h, b_v), pk(0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b1;
    first_tick("rel");
    repeat (3400) cycle();

    // Asynchronous reset in the middle of pixel (10,7) of the reduced raster.
    n = 0;
    while (!(sa.h == 10 && sa.v == 7 && sa.div == 1) && n < 3000) begin
      cycle();
      n++;
    end
    chk("mid_reach", n < 3000, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_a", pk(a_tick, a_ls, a_fs, a_act, a_hs, a_vs, a_h, a_v), pk(0, 0, 0, 0, 1, 1, 0, 0));
    chk("arst_b", pk(b_tick, b_ls, b_fs, b_act, b_hs, b_vs, b_h, b_v), pk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("arst_c", pk(c_tick, c_ls, c_fs, c_act, c_hs, c_vs, c_h, c_v), pk(0, 0, 0, 0, 1, 1, 0, 0));
    sa = m_reset(ga);
    sb = m_reset(gb);
    sc = m_reset(gc);
    repeat (3) cycle();
    rst_n = 1'b1;
    first_tick("arst");

    repeat (200) cycle();
    en = 1'b0;
    repeat (4) cycle();
    chk("dis_a", pk(a_tick, a_ls, a_fs, a_act, a_hs, a_vs, a_h, a_v), pk(0, 0, 0, 0, 1, 1, 0, 0));
    en = 1'b1;
    first_tick("ena");
    repeat (100) cycle();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
